tc_fetch_unit: RTL
==================

Name: tc_fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the 8-bit-address, 4-byte-wide combinational program memory.
- Owns the program counter and drives the memory address.
- Captures the four returned bytes into an instruction register.
- Hands the instruction downstream over a valid/ready handshake.
- Handles jump redirects (with flush) and stops fetching on a halt opcode.

Parameters:
- PC_WIDTH, 8, width of program counter and memory address.
- INSTR_STEP, 4, PC increment per fetched instruction (bytes per instruction).
- HALT_OPCODE, 8'hFF, opcode byte (in0) that stops fetching.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- address  output  PC_WIDTH  program memory address; combinationally equal to pc.
- in0  input  8  memory byte at address (opcode).
- in1  input  8  memory byte at address+1.
- in2  input  8  memory byte at address+2.
- in3  input  8  memory byte at address+3.
- jump_en  input  1  redirect request, sampled each rising edge.
- jump_target  input  PC_WIDTH  new pc when jump_en=1.
- instr_valid  output  1  instruction register holds an undelivered instruction.
- instr_ready  input  1  downstream accepts the instruction this cycle.
- instr_op  output  8  captured in0.
- instr_arg0  output  8  captured in1.
- instr_arg1  output  8  captured in2.
- instr_arg2  output  8  captured in3.
- instr_pc  output  PC_WIDTH  pc from which the instruction was fetched.
- halted  output  1  high while in HALT state.
- fetch_count  output  16  delivered-instruction counter (see Optional Feature).
- stall_count  output  16  backpressure cycle counter (see Optional Feature).

Behaviour:
- Reset (rst=1 at an edge): pc=0, state=FETCH. instr_valid=0; instr_op/arg0/arg1/arg2/instr_pc=0; halted=0; both counters=0. Reset overrides jump_en and the handshake, including mid-operation.
- Memory read is combinational: the bytes for address=pc are valid in the same cycle. Capture latency is 1 edge: the instruction at pc appears on the instr_* outputs the cycle after it is addressed.
- Slot free: free = !instr_valid || instr_ready.
- States: FETCH, HALT.
- FETCH, jump_en=0, free=1:
  - capture in0..in3 into the instruction register; instr_pc<=pc; instr_valid<=1.
  - If in0==HALT_OPCODE: state<=HALT, pc unchanged. Otherwise pc<=pc+INSTR_STEP, truncated to PC_WIDTH (252+4 wraps to 0).
- FETCH, jump_en=0, free=0: all registers hold (stall). The instr_* outputs must stay stable while valid&&!ready.
- HALT, jump_en=0:
  - No capture; pc holds; halted=1.
  - The halt instruction itself is delivered normally. instr_valid clears on instr_ready and then stays 0.
- jump_en=1, any state, has priority over capture:
  - pc<=jump_target; state<=FETCH; instr_valid<=0 (flush).
  - If the current instruction was handshaked in the same cycle (valid&&ready), it counts as delivered. If valid&&!ready, it is dropped.
  - instr_* data registers may hold stale values; they are don't-care while invalid.
- halted is registered: it goes 1 the edge the halt opcode is captured and 0 the edge a jump is taken.
- jump_target has no alignment requirement.

Optional Feature:
- Macro: TC_FETCH_PERF_COUNTERS_EN.
- Defined:
  - fetch_count increments on each edge with instr_valid&&instr_ready.
  - stall_count increments on each edge with instr_valid&&!instr_ready.
  - Both are 16-bit, wrap 16'hFFFF->0, and are cleared by rst.
- Undefined: no counter logic; both ports tied to 16'd0.

Test Plan:
- Sequential fetch: memory bytes 0..15 = 01 02 03 04 | 05 06 07 08 | 09 0A 0B 0C | ..., instr_ready=1 after reset.
  - Cycle 1 after reset: op=01, arg0..arg2=02/03/04, pc=0.
  - Next cycle: op=05, pc=4.
  - Next cycle: op=09, pc=8.
  - address steps 0,4,8,12.
- Backpressure: instr_valid=1 with op=05, instr_ready=0 for 3 cycles.
  - Outputs hold at op=05, pc=4; address holds 8.
  - stall_count=3 with macro.
  - Ready high: next edge shows pc=8.
- Jump flush: while valid&&!ready with pc=4, pulse jump_en with jump_target=8'h40.
  - Next edge: instr_valid=0, address=40.
  - Following edge: instr_pc=40; the pc=4 instruction is never delivered (fetch_count does not count it).
- Halt: byte at 0x0C = FF.
  - Edge capturing pc=0C: op=FF, valid=1, halted=1; address stays 0C.
  - After handshake: valid=0 for 5+ cycles, no new captures.
  - jump_en to 0x00: halted=0, fetch resumes with pc=0.
- Wrap: jump to FC with op≠FF, ready=1.
  - instr_pc=FC, next instr_pc=00.
- Reset mid-stall: valid=1, ready=0, then rst=1 for one edge.
  - Next cycle: valid=0, address=0, halted=0, counters=0.
  - Then fetch restarts from 0.

Source files
------------

// File: rtl/tc_fetch_unit_if.sv
// tc_fetch_unit_if: program-memory bus plus downstream instruction handshake.
`default_nettype none

interface tc_fetch_unit_if #(
  parameter int PC_WIDTH = 8
);
  logic [PC_WIDTH-1:0] address;
  logic [7:0]          in0;
  logic [7:0]          in1;
  logic [7:0]          in2;
  logic [7:0]          in3;
  logic                jump_en;
  logic [PC_WIDTH-1:0] jump_target;
  logic                instr_valid;
  logic                instr_ready;
  logic [7:0]          instr_op;
  logic [7:0]          instr_arg0;
  logic [7:0]          instr_arg1;
  logic [7:0]          instr_arg2;
  logic [PC_WIDTH-1:0] instr_pc;
  logic                halted;
  logic [15:0]         fetch_count;
  logic [15:0]         stall_count;

  modport master (
    output address, instr_valid, instr_op, instr_arg0, instr_arg1, instr_arg2,
           instr_pc, halted, fetch_count, stall_count,
    input  in0, in1, in2, in3, jump_en, jump_target, instr_ready
  );

  modport slave (
    input  address, instr_valid, instr_op, instr_arg0, instr_arg1, instr_arg2,
           instr_pc, halted, fetch_count, stall_count,
    output in0, in1, in2, in3, jump_en, jump_target, instr_ready
  );
endinterface

`default_nettype wire

// File: rtl/tc_fetch_unit.sv
// +--------------------------------------------------------------------------+
// | tc_fetch_unit: PC, instruction register, jump flush and halt detection.  |
// | Optional counters: TC_FETCH_PERF_COUNTERS_EN.   Revision: 1.0            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tc_fetch_unit #(
  parameter int         PC_WIDTH    = 8,
  parameter int         INSTR_STEP  = 4,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  wire              clk,
  input  wire              rst,
  tc_fetch_unit_if.master  bus
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_HALT  = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] pc, pc_next;
  logic                valid, valid_next;
  logic                capture;
  logic                free;
  logic [7:0]          op, arg0, arg1, arg2;
  logic [PC_WIDTH-1:0] ipc;

  assign free = !valid || bus.instr_ready;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    valid_next = valid && !bus.instr_ready;
    capture    = 1'b0;
    if (bus.jump_en) begin
      // Redirect wins over capture; any undelivered instruction is dropped.
      state_next = S_FETCH;
      pc_next    = bus.jump_target;
      valid_next = 1'b0;
    end else if (state == S_FETCH) begin
      if (free) begin
        capture    = 1'b1;
        valid_next = 1'b1;
        if (bus.in0 == HALT_OPCODE) begin
          state_next = S_HALT;
        end else begin
          pc_next = pc + PC_WIDTH'(INSTR_STEP);
        end
      end else begin
        valid_next = valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= '0;
      valid <= 1'b0;
      op    <= '0;
      arg0  <= '0;
      arg1  <= '0;
      arg2  <= '0;
      ipc   <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      valid <= valid_next;
      if (capture) begin
        op   <= bus.in0;
        arg0 <= bus.in1;
        arg1 <= bus.in2;
        arg2 <= bus.in3;
        ipc  <= pc;
      end
    end
  end

  assign bus.address     = pc;
  assign bus.instr_valid = valid;
  assign bus.instr_op    = op;
  assign bus.instr_arg0  = arg0;
  assign bus.instr_arg1  = arg1;
  assign bus.instr_arg2  = arg2;
  assign bus.instr_pc    = ipc;
  assign bus.halted      = (state == S_HALT);

`ifdef TC_FETCH_PERF_COUNTERS_EN
  logic [15:0] fetch_cnt, stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (valid && bus.instr_ready) fetch_cnt <= fetch_cnt + 16'd1;
      if (valid && !bus.instr_ready) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.fetch_count = fetch_cnt;
  assign bus.stall_count = stall_cnt;
`else
  assign bus.fetch_count = 16'd0;
  assign bus.stall_count = 16'd0;
`endif

endmodule

`default_nettype wire
